// File: rtl/pipe_pkg.sv
// Shared defaults for the arithmetic pipeline and its consumers, so that
// data width and latency stay the same on both sides.
package pipe_pkg;

  localparam int DATA_W   = 10;
  localparam int PIPE_LAT = 3;
  localparam int GRP_K    = 4;

  // Width of a K-result group total that can never wrap.
  function automatic int sum_w(input int n, input int k);
    return n + $clog2(k);
  endfunction

endpackage

// File: rtl/pipe_acc_if.sv
// Valid/ready channel carrying completed group totals out of pipe_acc.
interface pipe_acc_if #(
  parameter int SW = 12
);

  logic [SW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;

  modport master (
    output sum_out,
    output sum_valid,
    input  sum_ready
  );

  modport slave (
    input  sum_out,
    input  sum_valid,
    output sum_ready
  );

endinterface

// File: rtl/pipe_vdly.sv
// LAT-deep issue-aligned delay line; dout marks the cycle whose pipeline
// output belongs to an issued operand set.
module pipe_vdly
  import pipe_pkg::*;
#(
  parameter int LAT = PIPE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] v_r;

  // Shift register: stage 0 captures din, each later stage copies its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= {LAT{1'b0}};
    end else if (clear) begin
      v_r <= {LAT{1'b0}};
    end else begin
      v_r[0] <= din;
      for (int i = 1; i < LAT; i++) begin
        v_r[i] <= v_r[i-1];
      end
    end
  end

  assign dout = v_r[LAT-1];

endmodule

// File: rtl/pipe_acc.sv
// Group accumulator behind the non-stallable pipeline: sums every K valid
// results and presents each total on a valid/ready port with sticky overflow.
module pipe_acc
  import pipe_pkg::*;
#(
  parameter int  N   = DATA_W,
  parameter int  LAT = PIPE_LAT,
  parameter int  K   = GRP_K,
  localparam int SW  = sum_w(N, K),
  localparam int CW  = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic [N-1:0]  f,
  input  logic          clear,
  output logic [CW-1:0] grp_cnt,
  output logic          overflow,
  pipe_acc_if.master    sum_if
);

  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  logic          take_s;
  logic          complete_s;
  logic          accept_s;
  logic [SW-1:0] total_s;

  logic [SW-1:0] acc_r,       acc_s;
  logic [CW-1:0] grp_cnt_r,   grp_cnt_s;
  logic [SW-1:0] sum_out_r,   sum_out_s;
  logic          sum_valid_r, sum_valid_s;
  logic          overflow_r,  overflow_s;

  pipe_vdly #(
    .LAT (LAT)
  ) u_vdly (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .din   (issue),
    .dout  (take_s)
  );

  assign total_s    = acc_r + SW'(f);
  assign complete_s = take_s && (grp_cnt_r == LAST_CNT);
  assign accept_s   = sum_valid_r && sum_if.sum_ready;

  // Next-state for the accumulator (ACCUM) and the output holding register (HOLD).
  always_comb begin
    acc_s       = acc_r;
    grp_cnt_s   = grp_cnt_r;
    sum_out_s   = sum_out_r;
    sum_valid_s = sum_valid_r;
    overflow_s  = overflow_r;

    if (complete_s) begin
      acc_s     = {SW{1'b0}};
      grp_cnt_s = {CW{1'b0}};
    end else if (take_s) begin
      acc_s     = total_s;
      grp_cnt_s = grp_cnt_r + CW'(1);
    end else begin
      acc_s     = acc_r;
      grp_cnt_s = grp_cnt_r;
    end

    // A slot is free for the new total if empty or being drained this edge.
    if (complete_s) begin
      if (!sum_valid_r || sum_if.sum_ready) begin
        sum_out_s   = total_s;
        sum_valid_s = 1'b1;
      end else begin
        overflow_s  = 1'b1;
      end
    end else if (accept_s) begin
      sum_valid_s = 1'b0;
    end else begin
      sum_valid_s = sum_valid_r;
    end
  end

  // State registers; clear flushes everything and overrides take and accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {SW{1'b0}};
      grp_cnt_r   <= {CW{1'b0}};
      sum_out_r   <= {SW{1'b0}};
      sum_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (clear) begin
      acc_r       <= {SW{1'b0}};
      grp_cnt_r   <= {CW{1'b0}};
      sum_out_r   <= {SW{1'b0}};
      sum_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      acc_r       <= acc_s;
      grp_cnt_r   <= grp_cnt_s;
      sum_out_r   <= sum_out_s;
      sum_valid_r <= sum_valid_s;
      overflow_r  <= overflow_s;
    end
  end

  assign grp_cnt          = grp_cnt_r;
  assign overflow         = overflow_r;
  assign sum_if.sum_out   = sum_out_r;
  assign sum_if.sum_valid = sum_valid_r;

endmodule

// File: doc/pipe_acc.md
# pipe_acc

Downstream consumer of the 3-stage arithmetic pipeline, whose output is F = ((A+B)+(C−D))·D. The pipeline has no valid signal and cannot stall. This block tracks which of its output cycles carry real results, using an issue-aligned delay line, and sums every K consecutive results into a group total. Each total is presented on a valid/ready output port, with a sticky overflow flag for totals lost to backpressure.

## Interface
- N, 10: data width of F (matches the pipeline).
- LAT, 3: pipeline latency in clock edges from operand capture to F stable.
- K, 4: results per group; legal range K ≥ 2.
- SW, N+$clog2(K): width of sum_out; derived, not overridden.

Ports:
- clk  in  1  the only clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue  in  1  high in the cycle a valid operand set is driven into the pipeline.
- f  in  N  pipeline output F; unsigned.
- clear  in  1  synchronous flush of group, delay line, output and flag.
- sum_out  out  SW  completed group total.
- sum_valid  out  1  sum_out holds an unaccepted total.
- sum_ready  in  1  consumer accepts sum_out when high together with sum_valid.
- grp_cnt  out  $clog2(K)  results accumulated in the current group.
- overflow  out  1  sticky; a completed total was dropped.

## Operation
- Delay line v[0..LAT-1]: at each edge, v[0] ← issue and v[i] ← v[i-1].
- take = v[LAT-1] before the edge. When take is high, f is sampled at that edge.
- Arithmetic is unsigned and zero-extended to SW. A group total is at most K·(2^N−1), so it never wraps.
- On take with grp_cnt < K−1: acc ← acc + f and grp_cnt ← grp_cnt + 1.
- On take with grp_cnt = K−1 (completion): the total is acc + f; acc ← 0; grp_cnt ← 0.
- Output register on completion:
  - If sum_valid=0, or sum_valid=1 and sum_ready=1 at the same edge: sum_out ← total and sum_valid ← 1.
  - If sum_valid=1 and sum_ready=0: the old total is kept, the new total is dropped, and overflow ← 1.
- Accept without completion: sum_valid ← 0 and sum_out holds its value.
- overflow clears only on reset or clear.
- clear high overrides everything in the same edge, including take and accept. It zeroes v, acc, grp_cnt, sum_valid and overflow; sum_out ← 0.
- States are implicit: ACCUM (grp_cnt counting) and HOLD (sum_valid=1). The two are independent, so accumulation continues while HOLD waits on the consumer.

## Timing
- Reset values: sum_out=0, sum_valid=0, grp_cnt=0, overflow=0, v=0, acc=0.
- Reset asserted mid-group discards the partial group, and any results still in flight in the pipeline are never taken.
- issue sampled at edge t gives take high during the cycle after edge t+LAT−1, and f is sampled at edge t+LAT. With LAT=3, f is sampled three edges after issue.
- Completion at edge e makes sum_valid high immediately after edge e, so result-to-output latency is 1 cycle.
- Throughput: one result per cycle with no bubbles. Back-to-back issue is fully supported.
- The handshake transfers on any edge where sum_valid && sum_ready. sum_out and sum_valid do not depend combinationally on sum_ready.

## Structure
- Shared package pipe_pkg holds:
  - DATA_W = 10 and PIPE_LAT = 3, used as defaults by both the pipeline and this block so the latencies stay locked together;
  - the group-size default.
- Sub-module pipe_vdly: a parameterised LAT-deep 1-bit shift register with rst_n and clear, whose output is take. It is reusable by any future pipeline consumer.
- The accumulator, counter and output register stay in pipe_acc.

## Test plan
- Group sum: issue high 4 consecutive cycles with f=1,2,3,4 on the 4 take cycles, sum_ready=1 → one cycle after the 4th take, sum_out=10 and sum_valid=1 for exactly 1 cycle; grp_cnt sequence 1,2,3,0.
- Max values: 4 takes of f=1023 → sum_out=4092, no wrap in the 12-bit SW.
- Backpressure: sum_ready=0 across 2 full groups (1,1,1,1 then 2,2,2,2) → sum_out stays 4 and overflow=1. Then sum_ready=1 → one transfer of 4 and sum_valid drops.
- Simultaneous events: completion on the same edge as an accept of the previous total → new total loaded, sum_valid stays 1, overflow=0.
- Reset mid-group: 2 takes (f=5,6), then rst_n low for 1 cycle while 1 issue is in flight → all outputs 0. The next 4 takes of 1 give sum_out=4.
- Clear wins: clear high on the edge of a completing take with sum_valid=1 and overflow=1 → everything zero after the edge, and no total is presented.
